// File: rtl/write_axi256_dbg_pkg.sv
// rtl/write_axi256_dbg_pkg.sv - shared constants and FSM encoding for the write_axi256 deadlock reporter
//
// Contents:
//   *_DEF       default widths for the reporter parameters
//   state_t     reporter FSM encoding (IDLE=0, PENDING=1, DEADLOCK=2, 3 unused)
//   ST_RECOVER  state entered from the unused encoding
package write_axi256_dbg_pkg;

  localparam int INFO_W_DEF   = 1;
  localparam int THRESH_W_DEF = 16;
  localparam int RUN_W_DEF    = 32;
  localparam int STAT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_DEADLOCK = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

  localparam state_t ST_RECOVER = ST_IDLE;

endpackage

// File: rtl/wa256_sat_counter.sv
// rtl/wa256_sat_counter.sv - saturating up-counter with clear and load
//
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   inc           count up by one (holds at all-ones)
//   clr           return to zero; combined with inc the result is 1
//   load          overrides clr/inc and loads load_val
//   load_val      value loaded when load is high
//   q             counter value
module wa256_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  // Clear first, then increment, so a clear coinciding with an event counts that event.
  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc && (base != '1)) begin
      q <= base + ONE;
    end else begin
      q <= base;
    end
  end

endmodule

// File: rtl/write_axi256_deadlock_reporter.sv
// rtl/write_axi256_deadlock_reporter.sv - debounces the write_axi256 monitor block signal into deadlock reports
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   block_in         monitor block output
//   info_in          monitor blocked-stream info
//   threshold        consecutive blocked cycles that declare a deadlock (0 acts as 1)
//   clear            one-cycle clear of status and statistics
//   deadlock_irq     one-cycle pulse per declaration
//   deadlock_sticky  set on declaration, held until clear
//   first_info       info_in captured at the first declaration since clear
//   last_run         length of the most recently ended blocked episode
//   deadlock_count   saturating count of declarations
//   glitch_count     saturating count of episodes that ended below threshold
//   state_dbg        current FSM state
module write_axi256_deadlock_reporter
  import write_axi256_dbg_pkg::*;
#(
  parameter int INFO_W   = INFO_W_DEF,
  parameter int THRESH_W = THRESH_W_DEF,
  parameter int RUN_W    = RUN_W_DEF,
  parameter int STAT_W   = STAT_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block_in,
  input  logic [INFO_W-1:0]   info_in,
  input  logic [THRESH_W-1:0] threshold,
  input  logic                clear,
  output logic                deadlock_irq,
  output logic                deadlock_sticky,
  output logic [INFO_W-1:0]   first_info,
  output logic [RUN_W-1:0]    last_run,
  output logic [STAT_W-1:0]   deadlock_count,
  output logic [STAT_W-1:0]   glitch_count,
  output logic [1:0]          state_dbg
);

  // Threshold and run length are compared at the wider of the two widths so a
  // threshold beyond the run counter range simply never declares.
  localparam int CMP_W = (THRESH_W > RUN_W) ? THRESH_W : RUN_W;

  state_t           state;
  state_t           next_state;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic [CMP_W-1:0] eff_thresh;
  logic             reached;

  logic declare;
  logic glitch_end;
  logic episode_end;
  logic run_load;
  logic run_inc;
  logic run_clr;

  always_comb begin
    eff_thresh = (threshold == '0) ? CMP_W'(1) : CMP_W'(threshold);
    if (state == ST_IDLE) begin
      run_next = RUN_W'(1);
    end else if (run_cnt == '1) begin
      run_next = run_cnt;
    end else begin
      run_next = run_cnt + RUN_W'(1);
    end
    reached = (CMP_W'(run_next) >= eff_thresh);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    declare     = 1'b0;
    glitch_end  = 1'b0;
    episode_end = 1'b0;
    run_load    = 1'b0;
    run_inc     = 1'b0;
    run_clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (block_in) begin
          run_load = 1'b1;
          if (reached) begin
            declare    = 1'b1;
            next_state = ST_DEADLOCK;
          end else begin
            next_state = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (block_in) begin
          run_inc = 1'b1;
          // Also covers a threshold lowered below the current run.
          if (reached) begin
            declare    = 1'b1;
            next_state = ST_DEADLOCK;
          end
        end else begin
          next_state  = ST_IDLE;
          episode_end = 1'b1;
          glitch_end  = 1'b1;
          run_clr     = 1'b1;
        end
      end
      ST_DEADLOCK: begin
        if (block_in) begin
          run_inc = 1'b1;
        end else begin
          next_state  = ST_IDLE;
          episode_end = 1'b1;
          run_clr     = 1'b1;
        end
      end
      default: begin
        next_state = ST_RECOVER;
        run_clr    = 1'b1;
      end
    endcase
  end

  wa256_sat_counter #(.W(RUN_W)) u_run_cnt (
    .clock    (clock),
    .reset    (reset),
    .inc      (run_inc),
    .clr      (run_clr),
    .load     (run_load),
    .load_val (RUN_W'(1)),
    .q        (run_cnt)
  );

  wa256_sat_counter #(.W(STAT_W)) u_deadlock_count (
    .clock    (clock),
    .reset    (reset),
    .inc      (declare),
    .clr      (clear),
    .load     (1'b0),
    .load_val ('0),
    .q        (deadlock_count)
  );

  wa256_sat_counter #(.W(STAT_W)) u_glitch_count (
    .clock    (clock),
    .reset    (reset),
    .inc      (glitch_end),
    .clr      (clear),
    .load     (1'b0),
    .load_val ('0),
    .q        (glitch_count)
  );

  // A declaration outranks a same-cycle clear, including the first_info
  // capture: after the clear this is the first declaration.
  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock_irq    <= 1'b0;
      deadlock_sticky <= 1'b0;
      first_info      <= '0;
      last_run        <= '0;
    end else begin
      deadlock_irq <= declare;
      if (declare) begin
        deadlock_sticky <= 1'b1;
      end else if (clear) begin
        deadlock_sticky <= 1'b0;
      end
      if (declare && (!deadlock_sticky || clear)) begin
        first_info <= info_in;
      end else if (clear) begin
        first_info <= '0;
      end
      if (episode_end) begin
        last_run <= run_cnt;
      end else if (clear) begin
        last_run <= '0;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_write_axi256_deadlock_reporter.sv
// tb/tb_write_axi256_deadlock_reporter.sv - self-checking bench for write_axi256_deadlock_reporter
module tb_write_axi256_deadlock_reporter;

  typedef struct {
    int unsigned run;
    bit          decl;
    bit          irq;
    bit          sticky;
    bit          first;
    int unsigned last;
    int unsigned dcnt;
    int unsigned gcnt;
  } model_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        block1 = 1'b0, info1 = 1'b0, clr1 = 1'b0;
  logic [15:0] thr1 = 16'd4;
  logic        irq1, sticky1;
  logic [0:0]  first1;
  logic [31:0] last1;
  logic [15:0] dcnt1, gcnt1;
  logic [1:0]  st1;

  logic        block2 = 1'b0, info2 = 1'b0, clr2 = 1'b0;
  logic [15:0] thr2 = 16'd4;
  logic        irq2, sticky2;
  logic [0:0]  first2;
  logic [3:0]  last2;
  logic [1:0]  dcnt2, gcnt2;
  logic [1:0]  st2;

  model_t m1, m2;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  write_axi256_deadlock_reporter dut1 (
    .clock(clock), .reset(reset), .block_in(block1), .info_in(info1),
    .threshold(thr1), .clear(clr1), .deadlock_irq(irq1), .deadlock_sticky(sticky1),
    .first_info(first1), .last_run(last1), .deadlock_count(dcnt1),
    .glitch_count(gcnt1), .state_dbg(st1)
  );

  write_axi256_deadlock_reporter #(.RUN_W(4), .STAT_W(2)) dut2 (
    .clock(clock), .reset(reset), .block_in(block2), .info_in(info2),
    .threshold(thr2), .clear(clr2), .deadlock_irq(irq2), .deadlock_sticky(sticky2),
    .first_info(first2), .last_run(last2), .deadlock_count(dcnt2),
    .glitch_count(gcnt2), .state_dbg(st2)
  );

  // Episode-level reference: a run is a streak of blocked cycles; it is declared
  // once its length reaches the threshold, and ends when block drops.
  function automatic model_t model_step(model_t m, bit rst, bit blk, bit inf,
                                        int unsigned thr, bit clr,
                                        int unsigned run_max, int unsigned stat_max);
    model_t n;
    int unsigned eff;
    n = m;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    eff = (thr == 0) ? 1 : thr;
    n.irq = 1'b0;
    if (clr) begin
      n.sticky = 1'b0; n.first = 1'b0; n.dcnt = 0; n.gcnt = 0; n.last = 0;
    end
    if (blk) begin
      n.run = (m.run < run_max) ? m.run + 1 : run_max;
      if (!m.decl && n.run >= eff) begin
        n.decl = 1'b1;
        n.irq = 1'b1;
        n.sticky = 1'b1;
        if (!m.sticky || clr) n.first = inf;
        if (n.dcnt < stat_max) n.dcnt = n.dcnt + 1;
      end
    end else if (m.run > 0) begin
      n.last = m.run;
      if (!m.decl && n.gcnt < stat_max) n.gcnt = n.gcnt + 1;
      n.run = 0;
      n.decl = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [1:0] model_state(model_t m);
    if (m.run == 0) return 2'd0;
    return m.decl ? 2'd2 : 2'd1;
  endfunction

  task automatic tick();
    @(posedge clock);
    m1 = model_step(m1, reset, block1, info1, thr1, clr1, 32'hffff_ffff, 32'hffff);
    m2 = model_step(m2, reset, block2, info2, thr2, clr2, 15, 3);
    #1;
  endtask

  task automatic clear_pulse();
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL reset_irq act=%0b exp=0", irq1); end
    total++; if (sticky1 !== 1'b0) begin bad++; $display("FAIL reset_sticky act=%0b exp=0", sticky1); end
    total++; if ({first1, last1, dcnt1, gcnt1} !== '0) begin bad++; $display("FAIL reset_status act=%0h exp=0", {first1, last1, dcnt1, gcnt1}); end
    total++; if (st1 !== 2'd0) begin bad++; $display("FAIL reset_state act=%0d exp=0", st1); end
    total++; if ({irq2, sticky2, first2, last2, dcnt2, gcnt2, st2} !== '0) begin bad++; $display("FAIL reset_dut2 act=%0h exp=0", {irq2, sticky2, first2, last2, dcnt2, gcnt2, st2}); end
  endtask

  task automatic test_glitch();
    thr1 = 16'd4;
    block1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL glitch_irq cyc=%0d act=%0b exp=0", i, irq1); end
    end
    total++; if (st1 !== 2'd1) begin bad++; $display("FAIL glitch_pending act=%0d exp=1", st1); end
    block1 = 1'b0;
    tick();
    total++; if (gcnt1 !== 16'd1) begin bad++; $display("FAIL glitch_count act=%0d exp=1", gcnt1); end
    total++; if (last1 !== 32'd3) begin bad++; $display("FAIL glitch_last_run act=%0d exp=3", last1); end
    total++; if (st1 !== 2'd0 || sticky1 !== 1'b0) begin bad++; $display("FAIL glitch_idle state=%0d sticky=%0b exp 0/0", st1, sticky1); end
  endtask

  task automatic test_deadlock();
    clear_pulse();
    thr1 = 16'd4;
    info1 = 1'b1;
    block1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++; if (irq1 !== (i == 4)) begin bad++; $display("FAIL dl_irq cyc=%0d act=%0b exp=%0b", i, irq1, (i == 4)); end
    end
    total++; if (sticky1 !== 1'b1 || first1 !== 1'b1) begin bad++; $display("FAIL dl_sticky_first act=%0b/%0b exp=1/1", sticky1, first1); end
    total++; if (dcnt1 !== 16'd1 || st1 !== 2'd2) begin bad++; $display("FAIL dl_count_state act=%0d/%0d exp=1/2", dcnt1, st1); end
    block1 = 1'b0;
    info1 = 1'b0;
    tick();
    total++; if (last1 !== 32'd10) begin bad++; $display("FAIL dl_last_run act=%0d exp=10", last1); end
    total++; if (gcnt1 !== 16'd0 || st1 !== 2'd0) begin bad++; $display("FAIL dl_end glitch=%0d state=%0d exp 0/0", gcnt1, st1); end
  endtask

  task automatic test_immediate();
    for (int t = 0; t <= 1; t++) begin
      clear_pulse();
      thr1 = 16'(t);
      block1 = 1'b1;
      tick();
      block1 = 1'b0;
      total++; if (irq1 !== 1'b1 || dcnt1 !== 16'd1) begin bad++; $display("FAIL imm_declare thr=%0d irq=%0b cnt=%0d exp 1/1", t, irq1, dcnt1); end
      tick();
      total++; if (irq1 !== 1'b0 || gcnt1 !== 16'd0 || last1 !== 32'd1) begin bad++; $display("FAIL imm_end thr=%0d irq=%0b glitch=%0d last=%0d exp 0/0/1", t, irq1, gcnt1, last1); end
    end
  endtask

  task automatic test_sticky_first();
    clear_pulse();
    thr1 = 16'd2;
    info1 = 1'b1;
    block1 = 1'b1; tick(); tick(); block1 = 1'b0; tick();
    info1 = 1'b0;
    block1 = 1'b1; tick(); tick(); block1 = 1'b0; tick();
    total++; if (dcnt1 !== 16'd2 || first1 !== 1'b1) begin bad++; $display("FAIL second_dl cnt=%0d first=%0b exp 2/1", dcnt1, first1); end
    clear_pulse();
    total++; if ({sticky1, first1, last1, dcnt1, gcnt1} !== '0) begin bad++; $display("FAIL clear_status act=%0h exp=0", {sticky1, first1, last1, dcnt1, gcnt1}); end
    block1 = 1'b1; tick(); tick(); block1 = 1'b0; tick();
    total++; if (sticky1 !== 1'b1 || first1 !== 1'b0 || dcnt1 !== 16'd1) begin bad++; $display("FAIL third_dl sticky=%0b first=%0b cnt=%0d exp 1/0/1", sticky1, first1, dcnt1); end
  endtask

  task automatic test_clear_on_declare();
    thr1 = 16'd3;
    info1 = 1'b1;
    block1 = 1'b1;
    tick(); tick();
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    total++; if (irq1 !== 1'b1 || sticky1 !== 1'b1 || dcnt1 !== 16'd1) begin bad++; $display("FAIL clr_decl irq=%0b sticky=%0b cnt=%0d exp 1/1/1", irq1, sticky1, dcnt1); end
    total++; if (first1 !== 1'b1 || last1 !== 32'd0) begin bad++; $display("FAIL clr_decl_info first=%0b last=%0d exp 1/0", first1, last1); end
    block1 = 1'b0;
    info1 = 1'b0;
    tick();
    thr1 = 16'd4;
    block1 = 1'b1;
    tick(); tick();
    total++; if (st1 !== 2'd1) begin bad++; $display("FAIL pre_reset_pending act=%0d exp=1", st1); end
    reset = 1'b1;
    block1 = 1'b0;
    tick();
    reset = 1'b0;
    total++; if ({irq1, sticky1, first1, last1, dcnt1, gcnt1, st1} !== '0) begin bad++; $display("FAIL mid_reset act=%0h exp=0", {irq1, sticky1, first1, last1, dcnt1, gcnt1, st1}); end
    tick();
    total++; if (gcnt1 !== 16'd0 || last1 !== 32'd0) begin bad++; $display("FAIL post_reset glitch=%0d last=%0d exp 0/0", gcnt1, last1); end
  endtask

  task automatic test_saturation();
    thr2 = 16'd4;
    for (int i = 0; i < 5; i++) begin
      block2 = 1'b1; tick();
      block2 = 1'b0; tick();
    end
    total++; if (gcnt2 !== 2'd3) begin bad++; $display("FAIL glitch_sat act=%0d exp=3", gcnt2); end
    block2 = 1'b1;
    repeat (20) tick();
    block2 = 1'b0;
    tick();
    total++; if (last2 !== 4'd15) begin bad++; $display("FAIL run_sat act=%0d exp=15", last2); end
    total++; if (dcnt2 !== 2'd1 || gcnt2 !== 2'd3) begin bad++; $display("FAIL sat_counts dl=%0d gl=%0d exp 1/3", dcnt2, gcnt2); end
  endtask

  task automatic test_random();
    logic [68:0] act1, exp1;
    logic [11:0] act2, exp2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) block1 = ~block1;
      if ($urandom_range(3) == 0) block2 = ~block2;
      info1 = 1'($urandom);
      info2 = 1'($urandom);
      if ($urandom_range(15) == 0) thr1 = 16'($urandom_range(6));
      if ($urandom_range(15) == 0) thr2 = 16'($urandom_range(20));
      clr1 = ($urandom_range(15) == 0);
      clr2 = ($urandom_range(15) == 0);
      reset = ($urandom_range(199) == 0);
      tick();
      exp1 = {m1.irq, m1.sticky, m1.first, m1.last, m1.dcnt[15:0], m1.gcnt[15:0], model_state(m1)};
      act1 = {irq1, sticky1, first1, last1, dcnt1, gcnt1, st1};
      exp2 = {m2.irq, m2.sticky, m2.first, m2.last[3:0], m2.dcnt[1:0], m2.gcnt[1:0], model_state(m2)};
      act2 = {irq2, sticky2, first2, last2, dcnt2, gcnt2, st2};
      total++; if (act1 !== exp1) begin bad++; $display("FAIL rand_dut1 cyc=%0d act=%h exp=%h", i, act1, exp1); end
      total++; if (act2 !== exp2) begin bad++; $display("FAIL rand_dut2 cyc=%0d act=%h exp=%h", i, act2, exp2); end
    end
    reset = 1'b0;
    clr1 = 1'b0;
    clr2 = 1'b0;
  endtask

  initial begin
    m1 = '{default: 0};
    m2 = '{default: 0};
    test_reset();
    test_glitch();
    test_deadlock();
    test_immediate();
    test_sticky_first();
    test_clear_on_declare();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
